// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store, data first
// with a bounded streak so fetch cannot starve; redirected fetches are dropped.
module mem_arbiter #(
  parameter int MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic        i_flush,
  output logic        i_valid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_mask,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        mem_request,
  output logic        mem_we_re,
  output logic [3:0]  mem_mask,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  input  logic        mem_valid,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [SW-1:0] r_streak;
  logic          r_kill;
  logic          w_grant_d;
  logic          w_grant_i;

  // State register plus the datapath registers captured on a grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_streak    <= '0;
      r_kill      <= 1'b0;
      mem_we_re   <= 1'b0;
      mem_mask    <= 4'h0;
      mem_address <= 32'h0;
      mem_wdata   <= 32'h0;
    end else begin
      r_state <= w_next;

      if (w_grant_d) begin
        mem_we_re   <= d_we;
        mem_mask    <= d_mask;
        mem_address <= d_addr;
        mem_wdata   <= d_wdata;
      end else if (w_grant_i) begin
        mem_we_re   <= 1'b0;
        mem_mask    <= 4'hF;
        mem_address <= i_addr;
        mem_wdata   <= 32'h0;
      end

      if (r_state == IDLE) begin
        if (w_grant_d && i_req) begin
          if (r_streak < SW'(MAX_D_STREAK))
            r_streak <= r_streak + SW'(1);
        end else if (w_grant_i || !i_req) begin
          r_streak <= '0;
        end
      end

      // A flush on the completion cycle only matters combinationally, so
      // returning to IDLE always wins over setting the flag.
      if (w_next == IDLE)
        r_kill <= 1'b0;
      else if (r_state == BUSY_I && i_flush)
        r_kill <= 1'b1;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_grant_d = 1'b0;
    w_grant_i = 1'b0;
    case (r_state)
      IDLE: begin
        if (d_req && (!i_req || r_streak < SW'(MAX_D_STREAK))) begin
          w_grant_d = 1'b1;
          w_next    = BUSY_D;
        end else if (i_req && !i_flush) begin
          w_grant_i = 1'b1;
          w_next    = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_valid)
          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    mem_request = (r_state != IDLE);
    busy        = (r_state != IDLE);
    i_valid     = (r_state == BUSY_I) && mem_valid && !r_kill && !i_flush;
    d_valid     = (r_state == BUSY_D) && mem_valid;
    i_rdata     = i_valid ? mem_rdata : 32'h0;
    d_rdata     = d_valid ? mem_rdata : 32'h0;
  end

endmodule
